// File: rtl/miter_stim_if.sv
// Bundle between the miter stimulus driver and the gold/gate miter it exercises.
// The master side is the driver; the slave side is the miter plus whoever starts runs.
interface miter_stim_if #(
    parameter int IN_WIDTH  = 1,
    parameter int OUT_WIDTH = 1,
    parameter int CNT_W     = 16
);
    logic                 start;
    logic [CNT_W-1:0]     num_vectors;
    logic [IN_WIDTH-1:0]  pi_out;
    logic [OUT_WIDTH-1:0] mp_gold;
    logic [OUT_WIDTH-1:0] mp_gate;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     fail_index;
    logic [OUT_WIDTH-1:0] fail_gold;
    logic [OUT_WIDTH-1:0] fail_gate;
    logic [CNT_W-1:0]     fail_count;

    modport master (
        input  start, num_vectors, mp_gold, mp_gate,
        output pi_out, busy, done, pass, fail_index, fail_gold, fail_gate, fail_count
    );

    modport slave (
        output start, num_vectors, mp_gold, mp_gate,
        input  pi_out, busy, done, pass, fail_index, fail_gold, fail_gate, fail_count
    );
endinterface

// File: rtl/miter_stim_driver.sv
// Pseudo-random stimulus and X-tolerant gold/gate compare for EQY-style miters.
// Optional feature macro: MITER_STOP_ON_FAIL_EN (end the run at the first failing vector).
module miter_stim_driver #(
    parameter int          IN_WIDTH  = 1,
    parameter int          OUT_WIDTH = 1,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic            clk,
    input  logic            rst,
    miter_stim_if.master    bus
);

`ifdef MITER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [31:0]          r_lfsr;
    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_count;
    logic [IN_WIDTH-1:0]  r_pi_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [CNT_W-1:0]     r_fail_index;
    logic [OUT_WIDTH-1:0] r_fail_gold;
    logic [OUT_WIDTH-1:0] r_fail_gate;
    logic [CNT_W-1:0]     r_fail_count;

    logic [OUT_WIDTH-1:0] w_bit_ok;
    logic                 w_vec_fail;
    logic [31:0]          w_lfsr_next;
    logic [CNT_W-1:0]     w_idx_inc;
    logic [CNT_W-1:0]     w_fail_count_inc;
    logic                 w_stop;

    // An X on the gold side means "don't care"; synthesis treats the X test as false.
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_bit_ok
            assign w_bit_ok[gi] = (bus.mp_gold[gi] === 1'bx) ||
                                  (bus.mp_gold[gi] === bus.mp_gate[gi]);
        end
    endgenerate

    assign w_vec_fail       = ~(&w_bit_ok);
    assign w_lfsr_next      = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    assign w_idx_inc        = r_idx + 1'b1;
    assign w_fail_count_inc = (&r_fail_count) ? r_fail_count : r_fail_count + 1'b1;
    assign w_stop           = (w_idx_inc == r_count) || (STOP_ON_FAIL && w_vec_fail);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED;
            r_idx        <= '0;
            r_count      <= '0;
            r_pi_out     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_index <= '0;
            r_fail_gold  <= '0;
            r_fail_gate  <= '0;
            r_fail_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_lfsr       <= SEED;
                        r_idx        <= '0;
                        r_count      <= bus.num_vectors;
                        r_pass       <= 1'b1;
                        r_fail_index <= '0;
                        r_fail_gold  <= '0;
                        r_fail_gate  <= '0;
                        r_fail_count <= '0;
                        if (bus.num_vectors == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRIVE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_DRIVE: begin
                    r_pi_out <= r_lfsr[IN_WIDTH-1:0];
                    r_state  <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (w_vec_fail) begin
                        // r_pass is still set only before the first failure of the run.
                        if (r_pass) begin
                            r_fail_index <= r_idx;
                            r_fail_gold  <= bus.mp_gold;
                            r_fail_gate  <= bus.mp_gate;
                        end
                        r_pass       <= 1'b0;
                        r_fail_count <= w_fail_count_inc;
                    end
                    r_lfsr <= w_lfsr_next;
                    r_idx  <= w_idx_inc;
                    if (w_stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_DRIVE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pi_out     = r_pi_out;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.fail_index = r_fail_index;
    assign bus.fail_gold  = r_fail_gold;
    assign bus.fail_gate  = r_fail_gate;
    assign bus.fail_count = r_fail_count;

endmodule

// File: tb/tb_miter_stim_driver.sv
// Directed and randomized runs of miter_stim_driver against a vector-list model of the miter.
// Honours MITER_STOP_ON_FAIL_EN in its expectations.
module tb_miter_stim_driver;
    localparam int          IW   = 8;
    localparam int          OW   = 8;
    localparam int          CW   = 16;
    localparam logic [31:0] SEED = 32'h1;
    localparam int          MAXV = 64;

`ifdef MITER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    // Miter behaviour: gold mirrors pi_out, gate flips the bits given for the vector in SAMPLE.
    int          cur_mode;
    int          cur_vec;
    logic [OW-1:0] flip [MAXV];
    logic [IW-1:0] exp_pi [MAXV];

    miter_stim_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW)) bus ();

    miter_stim_driver #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.mp_gold = bus.pi_out;
        bus.mp_gate = bus.pi_out ^ flip[cur_vec];
        if (cur_mode == 3) begin
            bus.mp_gold = 'x;
            bus.mp_gate = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pi"},    32'(bus.pi_out),     32'h0);
        chk({tag, "_busy"},  32'(bus.busy),       32'h0);
        chk({tag, "_done"},  32'(bus.done),       32'h0);
        chk({tag, "_pass"},  32'(bus.pass),       32'h0);
        chk({tag, "_fidx"},  32'(bus.fail_index), 32'h0);
        chk({tag, "_fgold"}, 32'(bus.fail_gold),  32'h0);
        chk({tag, "_fgate"}, 32'(bus.fail_gate),  32'h0);
        chk({tag, "_fcnt"},  32'(bus.fail_count), 32'h0);
    endtask

    // One run measured from the accepting edge A; mode 0 clean, 1 bit0 on vectors 3/5,
    // 2 random mismatches, 3 gold=X gate=0. rst_at >= 0 asserts reset in that cycle.
    task automatic run(input string tag, input int n, input int mode,
                       input bit pulse_start, input int rst_at);
        int            first;
        int            stop_n;
        int            exp_cnt;
        int            c;
        int            busy_cycles;
        logic [31:0]   s;
        logic [IW-1:0] prev_pi;

        for (int k = 0; k < MAXV; k++) begin
            flip[k] = '0;
            if (mode == 1 && (k == 3 || k == 5)) flip[k] = 8'h01;
            if (mode == 2 && $urandom_range(0, 3) == 0) flip[k] = 8'($urandom_range(1, 255));
        end
        s = SEED;
        for (int k = 0; k < MAXV; k++) begin
            exp_pi[k] = s[IW-1:0];
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
        first = -1;
        for (int k = n - 1; k >= 0; k--) if (flip[k] != 0) first = k;
        stop_n  = (STOP && first >= 0) ? first + 1 : n;
        exp_cnt = 0;
        for (int k = 0; k < stop_n; k++) if (flip[k] != 0) exp_cnt++;

        @(negedge clk);
        prev_pi         = bus.pi_out;
        cur_mode        = mode;
        cur_vec         = 0;
        bus.start       = 1'b1;
        bus.num_vectors = CW'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c = 0;
        busy_cycles = 0;
        if (n == 0) begin
            chk({tag, "_n0_done"}, 32'(bus.done),   32'h1);
            chk({tag, "_n0_pass"}, 32'(bus.pass),   32'h1);
            chk({tag, "_n0_pi"},   32'(bus.pi_out), 32'(prev_pi));
        end else begin
            chk({tag, "_accept_done"}, 32'(bus.done), 32'h0);
        end
        while (!bus.done && c < 400) begin
            if (bus.busy) busy_cycles++;
            chk({tag, "_busy_xor_done"}, 32'(bus.busy & bus.done), 32'h0);
            cur_vec = c >> 1;
            if (c[0]) chk({tag, "_pi_vec"}, 32'(bus.pi_out), 32'(exp_pi[c >> 1]));
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk_reset_outputs({tag, "_midrst"});
                return;
            end
            bus.start       = pulse_start && (c < 2);
            bus.num_vectors = pulse_start ? CW'(n + 7) : CW'(n);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            c++;
        end
        chk({tag, "_done"},      32'(bus.done),       32'h1);
        chk({tag, "_busy"},      32'(bus.busy),       32'h0);
        chk({tag, "_latency"},   32'(c),              32'(2 * stop_n));
        chk({tag, "_busy_cyc"},  32'(busy_cycles),    32'(2 * stop_n));
        chk({tag, "_pass"},      32'(bus.pass),       32'(first < 0));
        chk({tag, "_fail_cnt"},  32'(bus.fail_count), 32'(exp_cnt));
        chk({tag, "_fail_idx"},  32'(bus.fail_index), (first < 0) ? 32'h0 : 32'(first));
        chk({tag, "_fail_gold"}, 32'(bus.fail_gold),  (first < 0) ? 32'h0 : 32'(exp_pi[first]));
        chk({tag, "_fail_gate"}, 32'(bus.fail_gate),
            (first < 0) ? 32'h0 : 32'(exp_pi[first] ^ flip[first]));
        $display("run %s: N=%0d mode=%0d done after %0d cycles pass=%0d fail_count=%0d fail_index=%0d",
                 tag, n, mode, c, bus.pass, bus.fail_count, bus.fail_index);
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        cur_mode        = 0;
        cur_vec         = 0;
        for (int k = 0; k < MAXV; k++) flip[k] = '0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run("clean8", 8, 0, 1'b0, -1);
        run("flip35", 8, 1, 1'b0, -1);
        run("zero",   0, 0, 1'b0, -1);
        run("rst_mid", 8, 0, 1'b0, 5);
        run("after_rst", 8, 0, 1'b0, -1);
        run("start_ign", 3, 0, 1'b1, -1);
        run("gold_x", 4, 3, 1'b0, -1);
        for (int r = 0; r < 8; r++) run("rand", $urandom_range(1, 24), 2, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
